// File: rtl/ofmap_axis_packer.sv
// Serialises one LANES-wide result vector into AXI4-Stream beats (conv: ELEM_WIDTH/lane, pool: 1 bit/lane).
// Latency: first beat the cycle after accept; one idle bubble per vector. Backpressure: TREADY low holds the current beat and blocks new vectors.
module ofmap_axis_packer #(
    parameter int LANES       = 256,
    parameter int ELEM_WIDTH  = 8,
    parameter int TDATA_WIDTH = 32,
    parameter int LANE_CNT_W  = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*ELEM_WIDTH-1:0] in_data,
    input  logic                        in_last,
    input  logic [1:0]                  operation,
    input  logic [LANE_CNT_W-1:0]       active_lanes,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic                        M_AXIS_TLAST,
    output logic                        busy,
    output logic                        cfg_err,
    output logic [15:0]                 frame_beats
);

    localparam int EPW_CONV = TDATA_WIDTH / ELEM_WIDTH;
    localparam int EPW_POOL = TDATA_WIDTH;
    localparam int SH_CONV  = EPW_CONV * ELEM_WIDTH;
    localparam int SH_POOL  = EPW_POOL * ELEM_WIDTH;
    // Padding lets a pool beat read a full TDATA_WIDTH lanes even past the vector end.
    localparam int SH_W     = (LANES + TDATA_WIDTH) * ELEM_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [SH_W-1:0]       sh_q, sh_d;
    logic [LANE_CNT_W-1:0] rem_q, rem_d;
    logic                  last_q, last_d;
    logic                  pool_q, pool_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [15:0]           fb_q, fb_d;

    logic        accept;
    logic        cfg_ok;
    logic        beat_fire;
    logic        final_beat;
    logic [31:0] epw;
    logic [31:0] rem32;

    assign in_ready      = (state_q == IDLE);
    assign busy          = (state_q == SEND);
    assign M_AXIS_TVALID = busy;
    assign cfg_err       = cfg_err_q;
    assign frame_beats   = fb_q;

    assign accept     = in_valid && in_ready;
    assign cfg_ok     = (operation <= 2'd1) && (active_lanes != '0)
                        && (active_lanes <= LANE_CNT_W'(LANES));
    assign epw        = pool_q ? 32'(EPW_POOL) : 32'(EPW_CONV);
    assign rem32      = 32'(rem_q);
    assign final_beat = (rem32 <= epw);
    assign beat_fire  = busy && M_AXIS_TREADY;

    assign M_AXIS_TLAST = busy && last_q && final_beat;

    // Lanes at or beyond the remaining count are masked so partial beats carry zeros.
    always_comb begin
        M_AXIS_TDATA = '0;
        if (busy) begin
            if (pool_q) begin
                for (int j = 0; j < EPW_POOL; j++) begin
                    if (32'(j) < rem32) M_AXIS_TDATA[j] = sh_q[j*ELEM_WIDTH];
                end
            end else begin
                for (int j = 0; j < EPW_CONV; j++) begin
                    if (32'(j) < rem32)
                        M_AXIS_TDATA[j*ELEM_WIDTH +: ELEM_WIDTH] = sh_q[j*ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        rem_d     = rem_q;
        last_d    = last_q;
        pool_d    = pool_q;
        cfg_err_d = cfg_err_q;
        fb_d      = fb_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cfg_ok) begin
                        state_d = SEND;
                        sh_d    = SH_W'(in_data);
                        rem_d   = active_lanes;
                        last_d  = in_last;
                        pool_d  = operation[0];
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (beat_fire) begin
                    rem_d = LANE_CNT_W'(rem32 - epw);
                    sh_d  = pool_q ? (sh_q >> SH_POOL) : (sh_q >> SH_CONV);
                    if (M_AXIS_TLAST)         fb_d = '0;
                    else if (fb_q != 16'hFFFF) fb_d = fb_q + 16'd1;
                    if (final_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            rem_q     <= '0;
            last_q    <= 1'b0;
            pool_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            fb_q      <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            rem_q     <= rem_d;
            last_q    <= last_d;
            pool_q    <= pool_d;
            cfg_err_q <= cfg_err_d;
            fb_q      <= fb_d;
        end
    end

endmodule

// File: tb/tb_ofmap_axis_packer.sv
// Randomised and directed bench for ofmap_axis_packer against a lane-indexed reference model.
module tb_ofmap_axis_packer;

    localparam int LANES = 256;
    localparam int EW    = 8;
    localparam int TW    = 32;
    localparam int LCW   = 9;

    typedef struct packed {
        logic [TW-1:0] d;
        logic          l;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*EW-1:0]   in_data;
    logic                  in_last;
    logic [1:0]            operation;
    logic [LCW-1:0]        active_lanes;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;
    logic [TW-1:0]         M_AXIS_TDATA;
    logic                  M_AXIS_TLAST;
    logic                  busy;
    logic                  cfg_err;
    logic [15:0]           frame_beats;

    int checks   = 0;
    int failures = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    logic  drv_done;
    logic  drv_to;
    logic  timed_out;
    int    stall_viol;
    int    nready_cyc;
    int    first_cyc;
    logic [LANES*EW-1:0] vec;

    ofmap_axis_packer #(
        .LANES(LANES), .ELEM_WIDTH(EW), .TDATA_WIDTH(TW), .LANE_CNT_W(LCW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .operation(operation), .active_lanes(active_lanes),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
        .busy(busy), .cfg_err(cfg_err), .frame_beats(frame_beats)
    );

    always #5 clk = ~clk;

    function automatic logic [LANES*EW-1:0] rand_vec();
        logic [LANES*EW-1:0] r;
        for (int i = 0; i < LANES*EW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: lane i goes to beat i/epw, slot i%epw.
    function automatic void model_push(input logic [LANES*EW-1:0] d, input logic [1:0] op,
                                       input int al, input logic last);
        int    epw;
        int    nb;
        beat_t b;
        epw = (op == 2'd0) ? TW / EW : TW;
        nb  = (al + epw - 1) / epw;
        for (int k = 0; k < nb; k++) begin
            b.d = '0;
            for (int p = 0; p < epw; p++) begin
                int i;
                i = k * epw + p;
                if (i < al) begin
                    if (op == 2'd0) b.d = b.d | (TW'(d[i*EW +: EW]) << (p * EW));
                    else            b.d[p] = d[i*EW];
                end
            end
            b.l = last && (k == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic send_vec(input logic [LANES*EW-1:0] d, input logic [1:0] op,
                            input int al, input logic last);
        int w;
        @(negedge clk);
        in_data      = d;
        operation    = op;
        active_lanes = LCW'(al);
        in_last      = last;
        in_valid     = 1'b1;
        w = 0;
        while (!in_ready && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            drv_to   = 1'b1;
            in_valid = 1'b0;
        end else begin
            if (op <= 2'd1 && al >= 1 && al <= LANES) model_push(d, op, al, last);
            @(negedge clk);
            in_valid     = 1'b0;
            in_data      = rand_vec();
            operation    = 2'($urandom);
            active_lanes = LCW'($urandom);
            in_last      = 1'($urandom);
        end
    endtask

    task automatic collect(input int pct, input int max_cyc);
        int            cyc;
        logic          prev_stall;
        logic [TW-1:0] prev_d;
        logic          prev_l;
        beat_t         b;
        obs_q.delete();
        stall_viol = 0;
        nready_cyc = 0;
        first_cyc  = -1;
        timed_out  = 1'b0;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        cyc        = 0;
        while (!(drv_done && obs_q.size() >= exp_q.size())) begin
            @(negedge clk);
            cyc++;
            if (cyc > max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            if (prev_stall && (!M_AXIS_TVALID || M_AXIS_TDATA !== prev_d || M_AXIS_TLAST !== prev_l))
                stall_viol++;
            if (in_ready && M_AXIS_TVALID) stall_viol++;
            if (!in_ready) nready_cyc++;
            M_AXIS_TREADY = ($urandom_range(0, 99) < pct);
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (first_cyc < 0) first_cyc = cyc;
                b.d = M_AXIS_TDATA;
                b.l = M_AXIS_TLAST;
                obs_q.push_back(b);
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_d     = M_AXIS_TDATA;
            prev_l     = M_AXIS_TLAST;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        operation = 2'd0; active_lanes = '0; M_AXIS_TREADY = 1'b0;
        drv_to = 1'b0; drv_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, M_AXIS_TVALID, M_AXIS_TLAST, busy, cfg_err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 10000",
                     {in_ready, M_AXIS_TVALID, M_AXIS_TLAST, busy, cfg_err});
        end
        checks++;
        if (M_AXIS_TDATA !== 32'h0) begin
            failures++; $display("FAIL reset_tdata: got %h required 00000000", M_AXIS_TDATA);
        end
        checks++;
        if (frame_beats !== 16'h0) begin
            failures++; $display("FAIL reset_frame_beats: got %0d required 0", frame_beats);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_conv_full();
        int    mism;
        beat_t b0;
        beat_t b63;
        for (int i = 0; i < LANES; i++) vec[i*EW +: EW] = 8'(i);
        exp_q.delete(); drv_done = 1'b0;
        fork
            begin send_vec(vec, 2'd0, 256, 1'b0); drv_done = 1'b1; end
            collect(100, 2000);
        join
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        mism = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) mism++;
        b0  = (obs_q.size() > 0)  ? obs_q[0]  : '0;
        b63 = (obs_q.size() > 63) ? obs_q[63] : '0;
        checks++;
        if (obs_q.size() != 64) begin
            failures++; $display("FAIL conv_full_beats: got %0d required 64", obs_q.size());
        end
        checks++;
        if (b0 !== {32'h03020100, 1'b0}) begin
            failures++; $display("FAIL conv_full_beat0: got %h/%b required 03020100/0", b0.d, b0.l);
        end
        checks++;
        if (b63 !== {32'hFFFEFDFC, 1'b0}) begin
            failures++; $display("FAIL conv_full_beat63: got %h/%b required fffefdfc/0", b63.d, b63.l);
        end
        checks++;
        if (mism != 0) begin
            failures++; $display("FAIL conv_full_model: got %0d mismatching beats required 0", mism);
        end
        checks++;
        if (first_cyc != 2) begin
            failures++; $display("FAIL conv_full_latency: got first beat at cycle %0d required 2", first_cyc);
        end
        checks++;
        if (nready_cyc != 64) begin
            failures++; $display("FAIL conv_full_inready_low: got %0d cycles required 64", nready_cyc);
        end
        checks++;
        if ({in_ready, M_AXIS_TVALID} !== 2'b10) begin
            failures++; $display("FAIL conv_full_return_idle: got %b required 10", {in_ready, M_AXIS_TVALID});
        end
        checks++;
        if (frame_beats !== 16'd64) begin
            failures++; $display("FAIL conv_full_frame_beats: got %0d required 64", frame_beats);
        end
        checks++;
        if ((timed_out | drv_to) !== 1'b0) begin
            failures++; $display("FAIL conv_full_timeout: got %b required 0", timed_out | drv_to);
        end
    endtask

    task automatic test_conv_last();
        beat_t b0;
        beat_t b1;
        for (int i = 0; i < LANES; i++) vec[i*EW +: EW] = 8'(i);
        exp_q.delete(); drv_done = 1'b0;
        fork
            begin send_vec(vec, 2'd0, 6, 1'b1); drv_done = 1'b1; end
            collect(50, 2000);
        join
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        b0 = (obs_q.size() > 0) ? obs_q[0] : '0;
        b1 = (obs_q.size() > 1) ? obs_q[1] : '0;
        checks++;
        if (obs_q.size() != 2) begin
            failures++; $display("FAIL conv_last_beats: got %0d required 2", obs_q.size());
        end
        checks++;
        if (b0 !== {32'h03020100, 1'b0}) begin
            failures++; $display("FAIL conv_last_beat0: got %h/%b required 03020100/0", b0.d, b0.l);
        end
        checks++;
        if (b1 !== {32'h00000504, 1'b1}) begin
            failures++; $display("FAIL conv_last_beat1: got %h/%b required 00000504/1", b1.d, b1.l);
        end
        checks++;
        if (frame_beats !== 16'd0) begin
            failures++; $display("FAIL conv_last_frame_beats: got %0d required 0", frame_beats);
        end
        checks++;
        if (stall_viol != 0) begin
            failures++; $display("FAIL conv_last_stall_stable: got %0d violations required 0", stall_viol);
        end
    endtask

    task automatic test_pool();
        beat_t b0;
        beat_t b1;
        vec = rand_vec();
        for (int i = 0; i < 40; i++) vec[i*EW] = (i % 2 == 0);
        for (int i = 40; i < LANES; i++) vec[i*EW] = 1'b1;
        exp_q.delete(); drv_done = 1'b0;
        fork
            begin send_vec(vec, 2'd1, 40, 1'b1); drv_done = 1'b1; end
            collect(50, 2000);
        join
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        b0 = (obs_q.size() > 0) ? obs_q[0] : '0;
        b1 = (obs_q.size() > 1) ? obs_q[1] : '0;
        checks++;
        if (obs_q.size() != 2) begin
            failures++; $display("FAIL pool_beats: got %0d required 2", obs_q.size());
        end
        checks++;
        if (b0 !== {32'h55555555, 1'b0}) begin
            failures++; $display("FAIL pool_beat0: got %h/%b required 55555555/0", b0.d, b0.l);
        end
        checks++;
        if (b1 !== {32'h00000055, 1'b1}) begin
            failures++; $display("FAIL pool_beat1: got %h/%b required 00000055/1", b1.d, b1.l);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] ops [3];
        int         als [3];
        int         tv_cnt;
        int         nr_cnt;
        int         mism;
        ops = '{2'd0, 2'd2, 2'd1};
        als = '{0, 10, 257};
        for (int t = 0; t < 3; t++) begin
            exp_q.delete();
            send_vec(rand_vec(), ops[t], als[t], 1'b1);
            tv_cnt = 0; nr_cnt = 0;
            repeat (6) begin
                @(negedge clk);
                if (M_AXIS_TVALID) tv_cnt++;
                if (!in_ready) nr_cnt++;
            end
            checks++;
            if ({tv_cnt, nr_cnt, exp_q.size()} != 96'd0 || drv_to !== 1'b0) begin
                failures++;
                $display("FAIL illegal_consumed[%0d]: got tvalid_cycles=%0d inready_low=%0d drv_timeout=%b required 0/0/0",
                         t, tv_cnt, nr_cnt, drv_to);
            end
            checks++;
            if (cfg_err !== 1'b1) begin
                failures++; $display("FAIL illegal_cfg_err[%0d]: got %b required 1", t, cfg_err);
            end
        end
        for (int i = 0; i < LANES; i++) vec[i*EW +: EW] = 8'(i + 8'h40);
        exp_q.delete(); drv_done = 1'b0;
        fork
            begin send_vec(vec, 2'd0, 5, 1'b0); drv_done = 1'b1; end
            collect(70, 2000);
        join
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        mism = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) mism++;
        checks++;
        if (obs_q.size() != 2 || mism != 0) begin
            failures++; $display("FAIL illegal_then_legal: got %0d beats %0d bad required 2 beats 0 bad", obs_q.size(), mism);
        end
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++; $display("FAIL cfg_err_sticky: got %b required 1", cfg_err);
        end
    endtask

    task automatic test_reset_mid_send();
        int tv_cnt;
        for (int i = 0; i < LANES; i++) vec[i*EW +: EW] = 8'(i);
        exp_q.delete();
        M_AXIS_TREADY = 1'b1;
        send_vec(vec, 2'd0, 256, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if ({M_AXIS_TVALID, M_AXIS_TDATA} !== {1'b1, 32'h2B2A2928}) begin
            failures++; $display("FAIL mid_send_beat10: got %b/%h required 1/2b2a2928", M_AXIS_TVALID, M_AXIS_TDATA);
        end
        checks++;
        if (frame_beats !== 16'd12) begin
            failures++; $display("FAIL mid_send_frame_beats: got %0d required 12", frame_beats);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({M_AXIS_TVALID, in_ready, busy, M_AXIS_TLAST, cfg_err} !== 5'b01000 || M_AXIS_TDATA !== 32'h0) begin
            failures++;
            $display("FAIL mid_send_reset: got tvalid/in_ready/busy/tlast/cfg_err=%b tdata=%h required 01000 00000000",
                     {M_AXIS_TVALID, in_ready, busy, M_AXIS_TLAST, cfg_err}, M_AXIS_TDATA);
        end
        checks++;
        if (frame_beats !== 16'd0) begin
            failures++; $display("FAIL mid_send_reset_frame: got %0d required 0", frame_beats);
        end
        rst_n = 1'b1;
        tv_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (M_AXIS_TVALID) tv_cnt++;
        end
        checks++;
        if (tv_cnt != 0) begin
            failures++; $display("FAIL mid_send_discard: got %0d valid cycles after reset required 0", tv_cnt);
        end
        M_AXIS_TREADY = 1'b0;
    endtask

    task automatic test_random();
        int mism;
        int first_bad;
        int exp_fb;
        exp_q.delete(); drv_done = 1'b0; drv_to = 1'b0;
        fork
            begin
                for (int v = 0; v < 1000; v++) begin
                    logic [1:0] op;
                    int         al;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    op = 2'($urandom_range(0, 1));
                    al = ($urandom_range(0, 49) == 0) ? 256 : $urandom_range(1, 48);
                    send_vec(rand_vec(), op, al, ($urandom_range(0, 3) == 0));
                    if (drv_to) break;
                end
                drv_done = 1'b1;
            end
            collect(50, 60000);
        join
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        mism = 0; first_bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        exp_fb = 0;
        foreach (exp_q[i]) exp_fb = exp_q[i].l ? 0 : exp_fb + 1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL random_beat_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (mism != 0) begin
            failures++; $display("FAIL random_scoreboard: got %0d bad beats (first at %0d) required 0", mism, first_bad);
        end
        checks++;
        if (stall_viol != 0) begin
            failures++; $display("FAIL random_stall_stable: got %0d violations required 0", stall_viol);
        end
        checks++;
        if (32'(frame_beats) != exp_fb) begin
            failures++; $display("FAIL random_frame_beats: got %0d required %0d", frame_beats, exp_fb);
        end
        checks++;
        if ((timed_out | drv_to) !== 1'b0) begin
            failures++; $display("FAIL random_timeout: got %b required 0", timed_out | drv_to);
        end
    endtask

    initial begin
        test_reset();
        test_conv_full();
        test_conv_last();
        test_pool();
        test_illegal();
        test_reset_mid_send();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
